// File: rtl/pcm_delay_if.sv
// pcm_delay_if
// Bundles the per-channel delay-line signals so a channel can be passed around
// as one object.
//   delay             requested extra delay in samples (0 .. 2^DELAY_WIDTH-1)
//   pcm_data          input PCM sample, one per clock
//   delayed_pcm_data  registered delayed sample
// master modport: the side that drives samples and delay (e.g. steering wrapper)
// slave modport:  the delay line itself
interface pcm_delay_if #(
    parameter int DATA_WIDTH  = 19,
    parameter int DELAY_WIDTH = 5
);
    logic [DELAY_WIDTH-1:0] delay;
    logic [DATA_WIDTH-1:0]  pcm_data;
    logic [DATA_WIDTH-1:0]  delayed_pcm_data;

    modport master (
        output delay,
        output pcm_data,
        input  delayed_pcm_data
    );

    modport slave (
        input  delay,
        input  pcm_data,
        output delayed_pcm_data
    );
endinterface

// File: rtl/pcm_delay_line.sv
// pcm_delay_line
// Integer-sample delay for one microphone channel. Keeps the last
// 2^DELAY_WIDTH input samples and registers the sample from `delay` clocks ago.
// Ports:
//   clk   sample clock, one sample accepted per rising edge
//   rst   synchronous active-low reset (clears history and output)
//   bus   pcm_delay_if slave: delay, pcm_data in; delayed_pcm_data out
module pcm_delay_line #(
    parameter int DATA_WIDTH  = 19,
    parameter int DELAY_WIDTH = 5
) (
    input  logic        clk,
    input  logic        rst,
    pcm_delay_if.slave  bus
);
    localparam int DEPTH = 1 << DELAY_WIDTH;

    logic [DATA_WIDTH-1:0]  hist [DEPTH];
    logic [DELAY_WIDTH-1:0] wr_ptr;
    logic [DELAY_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [DATA_WIDTH-1:0]  out_q;

    // wr_ptr is the slot about to be written, so the newest stored sample sits
    // at wr_ptr-1 and h[delay-1] sits at wr_ptr-delay. The 5-bit subtraction
    // wraps naturally. For delay=0 that address is the oldest slot, which is
    // being overwritten this edge, so the live input is taken instead.
    assign rd_ptr  = wr_ptr - bus.delay;
    assign rd_data = (bus.delay == '0) ? bus.pcm_data : hist[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
            wr_ptr <= '0;
            out_q  <= '0;
        end else begin
            hist[wr_ptr] <= bus.pcm_data;
            wr_ptr       <= wr_ptr + DELAY_WIDTH'(1);
            out_q        <= rd_data;
        end
    end

    assign bus.delayed_pcm_data = out_q;
endmodule

// File: tb/tb_pcm_delay_line.sv
// tb_pcm_delay_line
// Directed bench for pcm_delay_line. Each step drives one sample, computes the
// expected output from a 32-deep shift-register reference, queues it, and
// compares once the DUT has registered the edge.
module tb_pcm_delay_line;
    logic clk;
    logic rst;

    pcm_delay_if #(.DATA_WIDTH(19), .DELAY_WIDTH(5)) bus ();

    pcm_delay_line #(.DATA_WIDTH(19), .DELAY_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [18:0] model [32];
    logic [18:0] exp_q [$];
    logic [18:0] obs_last;
    int          total_cnt = 0;
    int          pass_cnt  = 0;
    int          ramp;

    task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic step(input logic r, input logic [4:0] d, input logic [18:0] x, input string tag);
        logic [18:0] e;
        @(negedge clk);
        rst          = r;
        bus.delay    = d;
        bus.pcm_data = x;
        if (!r) begin
            e = '0;
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else begin
            e = (d == 5'd0) ? x : model[d - 5'd1];
            for (int i = 31; i > 0; i--) model[i] = model[i-1];
            model[0] = x;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs_last = bus.delayed_pcm_data;
        check(tag, obs_last, exp_q.pop_front());
    endtask

    initial begin
        rst          = 1'b0;
        bus.delay    = 5'd0;
        bus.pcm_data = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        // reset with all-ones input, then release at delay 5
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 19'h7FFFF, "reset_hold");
        check("reset_out_zero", obs_last, 19'h0);
        for (int i = 1; i <= 5; i++) step(1'b1, 5'd5, 19'h7FFFF, "post_reset_d5");
        check("post_reset_still_zero", obs_last, 19'h0);

        // fixed delay 4 on a ramp
        step(1'b0, 5'd4, 19'h0, "reset_before_ramp");
        for (ramp = 1; ramp <= 20; ramp++) begin
            step(1'b1, 5'd4, 19'(ramp), "ramp_d4");
            if (ramp == 10) check("ramp_d4_n10", obs_last, 19'd6);
        end

        // delay 0: same-edge capture
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 5'd0, 19'(ramp), "ramp_d0");
            check("d0_passthrough", obs_last, 19'(ramp));
            ramp++;
        end

        // delay 31 over 100 edges, several buffer laps
        step(1'b0, 5'd31, 19'h0, "reset_before_d31");
        for (ramp = 1; ramp <= 100; ramp++) begin
            step(1'b1, 5'd31, 19'(ramp), "ramp_d31");
            if (ramp == 32) check("d31_first", obs_last, 19'd1);
            if (ramp == 100) check("d31_last", obs_last, 19'd69);
        end

        // live delay change 10 -> 2 -> 10
        step(1'b0, 5'd10, 19'h0, "reset_before_live");
        for (ramp = 1; ramp <= 49; ramp++) step(1'b1, 5'd10, 19'(ramp), "live_d10");
        check("live_before_switch", obs_last, 19'd39);
        for (ramp = 50; ramp <= 60; ramp++) begin
            step(1'b1, 5'd2, 19'(ramp), "live_d2");
            if (ramp == 50) check("live_jump_48", obs_last, 19'd48);
        end
        for (ramp = 61; ramp <= 75; ramp++) begin
            step(1'b1, 5'd10, 19'(ramp), "live_back_d10");
            if (ramp == 61) check("live_back_51", obs_last, 19'd51);
        end

        // mid-stream reset at edge 20
        step(1'b0, 5'd3, 19'h0, "reset_before_mid");
        for (ramp = 1; ramp <= 19; ramp++) step(1'b1, 5'd3, 19'(ramp), "mid_d3");
        step(1'b0, 5'd3, 19'd20, "mid_reset_pulse");
        check("mid_reset_zero", obs_last, 19'h0);
        for (ramp = 1; ramp <= 10; ramp++) begin
            step(1'b1, 5'd3, 19'(ramp + 100), "mid_after");
            if (ramp == 4) check("mid_first_new", obs_last, 19'd101);
        end

        // data integrity at delay 7
        for (int i = 0; i < 20; i++)
            step(1'b1, 5'd7, (i % 2 == 0) ? 19'h55555 : 19'h2AAAA, "alt_d7");
        for (int i = 0; i < 40; i++)
            step(1'b1, 5'd7, 19'($urandom), "rand_d7");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
